// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter (reverse double dabble).
// Runs one shift-and-correct step per clock, with a start/busy/done handshake.
module bcd_to_binary #(
  parameter int unsigned DIGITS_IN = 3,
  parameter int unsigned BITS_OUT  = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*DIGITS_IN-1:0] bcd,
  output logic                   busy,
  output logic                   done,
  output logic [BITS_OUT-1:0]    binary,
  output logic                   error,
  output logic                   overflow
);

  localparam int unsigned BcdW  = 4 * DIGITS_IN;
  localparam int unsigned WorkW = BcdW + BITS_OUT;
  localparam int unsigned CntW  = (BITS_OUT > 1) ? $clog2(BITS_OUT) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e               state_q;
  logic [WorkW-1:0]     work_q;
  logic [CntW-1:0]      cnt_q;
  logic [WorkW-1:0]     shifted;
  logic [BcdW-1:0]      sh_bcd;
  logic [BITS_OUT-1:0]  sh_bin;
  logic                 bcd_invalid;
  logic                 last_step;

  // Shift right, then pull every BCD digit that reached 8+ back down by 3.
  always_comb begin
    shifted = work_q >> 1;
    sh_bin  = shifted[BITS_OUT-1:0];
    sh_bcd  = shifted[WorkW-1:BITS_OUT];
    for (int i = 0; i < int'(DIGITS_IN); i++) begin
      if (sh_bcd[4*i +: 4] >= 4'd8) begin
        sh_bcd[4*i +: 4] = sh_bcd[4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    bcd_invalid = 1'b0;
    for (int i = 0; i < int'(DIGITS_IN); i++) begin
      if (bcd[4*i +: 4] > 4'd9) begin
        bcd_invalid = 1'b1;
      end
    end
  end

  assign last_step = (cnt_q == CntW'(BITS_OUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      work_q   <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      binary   <= '0;
      error    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy <= 1'b1;
            if (bcd_invalid) begin
              state_q  <= StDone;
              done     <= 1'b1;
              error    <= 1'b1;
              binary   <= '0;
              overflow <= 1'b0;
            end else begin
              state_q <= StShift;
              work_q  <= {bcd, {BITS_OUT{1'b0}}};
              cnt_q   <= '0;
            end
          end
        end
        StShift: begin
          work_q <= {sh_bcd, sh_bin};
          cnt_q  <= cnt_q + 1'b1;
          if (last_step) begin
            state_q  <= StDone;
            done     <= 1'b1;
            binary   <= sh_bin;
            overflow <= |sh_bcd;
            error    <= 1'b0;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench: a 10-bit and an 8-bit converter driven with directed and
// random BCD operands, checked against a decimal-arithmetic reference model.
module tb_bcd_to_binary;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, start_b;
  logic [11:0] bcd_a, bcd_b;
  logic       busy_a, done_a, err_a, ovf_a;
  logic       busy_b, done_b, err_b, ovf_b;
  logic [9:0] bin_a;
  logic [7:0] bin_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd_to_binary #(.DIGITS_IN(3), .BITS_OUT(10)) dut (
    .clk(clk), .reset(reset), .start(start_a), .bcd(bcd_a), .busy(busy_a),
    .done(done_a), .binary(bin_a), .error(err_a), .overflow(ovf_a)
  );

  bcd_to_binary #(.DIGITS_IN(3), .BITS_OUT(8)) dut8 (
    .clk(clk), .reset(reset), .start(start_b), .bcd(bcd_b), .busy(busy_b),
    .done(done_b), .binary(bin_b), .error(err_b), .overflow(ovf_b)
  );

  // Decimal reference: digit value sum, range check against 2^bw.
  function automatic void ref_model(input logic [11:0] v, input int bw,
                                    output logic [9:0] bin, output logic err,
                                    output logic ovf);
    int d0, d1, d2, val;
    d0 = int'(v[3:0]);
    d1 = int'(v[7:4]);
    d2 = int'(v[11:8]);
    err = (d0 > 9) || (d1 > 9) || (d2 > 9);
    if (err) begin
      bin = '0;
      ovf = 1'b0;
    end else begin
      val = d2 * 100 + d1 * 10 + d0;
      ovf = (val >= (1 << bw));
      bin = 10'(val % (1 << bw));
    end
  endfunction

  // Runs one conversion and returns what was observed; latency counts edges after acceptance.
  task automatic convert(input bit w8, input logic [11:0] v, output int lat,
                         output logic [9:0] bin, output logic err, output logic ovf,
                         output bit busy_ok);
    logic dn, bz;
    @(negedge clk);
    if (w8) begin start_b = 1'b1; bcd_b = v; end
    else    begin start_a = 1'b1; bcd_a = v; end
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    dn = w8 ? done_b : done_a;
    while (!dn && lat < 40) begin
      bz = w8 ? busy_b : busy_a;
      if (!bz) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
      dn = w8 ? done_b : done_a;
    end
    bz  = w8 ? busy_b : busy_a;
    if (!bz) busy_ok = 1'b0;
    bin = w8 ? {2'b00, bin_b} : bin_a;
    err = w8 ? err_b : err_a;
    ovf = w8 ? ovf_b : ovf_a;
    @(posedge clk);
    #1;
    bz = w8 ? busy_b : busy_a;
    if (bz) busy_ok = 1'b0;
  endtask

  task automatic check_conv(input string name, input bit w8, input logic [11:0] v);
    int lat, exp_lat;
    logic [9:0] bin, ebin;
    logic err, ovf, eerr, eovf;
    bit busy_ok;
    convert(w8, v, lat, bin, err, ovf, busy_ok);
    ref_model(v, w8 ? 8 : 10, ebin, eerr, eovf);
    exp_lat = eerr ? 0 : (w8 ? 8 : 10);
    tests++;
    if (bin !== ebin || err !== eerr || ovf !== eovf) begin
      fails++;
      $display("FAIL %s bcd=%h: got bin=%0d err=%b ovf=%b, want bin=%0d err=%b ovf=%b",
               name, v, bin, err, ovf, ebin, eerr, eovf);
    end
    tests++;
    if (lat !== exp_lat) begin
      fails++;
      $display("FAIL %s_latency bcd=%h: got %0d, want %0d", name, v, lat, exp_lat);
    end
    tests++;
    if (busy_ok !== 1'b1) begin
      fails++;
      $display("FAIL %s_busy bcd=%h: got busy profile bad, want high until done then low",
               name, v);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy_a, done_a, bin_a, err_a, ovf_a} !== '0 ||
        {busy_b, done_b, bin_b, err_b, ovf_b} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got a=%b/%b/%0d/%b/%b b=%b/%b/%0d/%b/%b, want all 0",
               busy_a, done_a, bin_a, err_a, ovf_a, busy_b, done_b, bin_b, err_b, ovf_b);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    check_conv("dir_255", 1'b0, 12'h255);
    check_conv("dir_999", 1'b0, 12'h999);
    check_conv("dir_000", 1'b0, 12'h000);
  endtask

  task automatic test_invalid();
    check_conv("inv_1a3", 1'b0, 12'h1A3);
    check_conv("after_inv_042", 1'b0, 12'h042);
    check_conv("inv_f00", 1'b1, 12'hF00);
  endtask

  task automatic test_overflow();
    check_conv("ovf_300", 1'b1, 12'h300);
    check_conv("ovf_255", 1'b1, 12'h255);
    check_conv("ovf_256", 1'b1, 12'h256);
  endtask

  task automatic test_random();
    logic [11:0] v;
    for (int i = 0; i < 30; i++) begin
      for (int d = 0; d < 3; d++) begin
        // Mostly valid digits, occasionally an illegal nibble.
        v[4*d +: 4] = ($urandom_range(0, 15) == 0) ? 4'(10 + $urandom_range(0, 5))
                                                 : 4'($urandom_range(0, 9));
      end
      check_conv("rand10", 1'b0, v);
      check_conv("rand8", 1'b1, v);
    end
  endtask

  task automatic test_ignore_start();
    logic [9:0] prev;
    int n;
    bit busy_ok, hold_ok;
    prev = bin_a;
    @(negedge clk);
    start_a = 1'b1;
    bcd_a   = 12'h123;
    @(posedge clk);
    #1;
    n = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (!done_a && n < 40) begin
      if (!busy_a) busy_ok = 1'b0;
      if (bin_a !== prev) hold_ok = 1'b0;
      @(negedge clk);
      bcd_a   = 12'h777;
      start_a = n[0];
      @(posedge clk);
      #1;
      n++;
    end
    start_a = 1'b0;
    tests++;
    if (bin_a !== 10'd123 || n !== 10) begin
      fails++;
      $display("FAIL ignore_start: got bin=%0d lat=%0d, want bin=123 lat=10", bin_a, n);
    end
    tests++;
    if (!busy_ok || !hold_ok) begin
      fails++;
      $display("FAIL ignore_busy_hold: got busy_ok=%b hold_ok=%b, want 1 1", busy_ok, hold_ok);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int last, ndone;
    bit gap_ok, val_ok;
    @(negedge clk);
    start_a = 1'b1;
    bcd_a   = 12'h042;
    last = -1;
    ndone = 0;
    gap_ok = 1'b1;
    val_ok = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (done_a) begin
        if (last >= 0 && c - last != 12) gap_ok = 1'b0;
        if (bin_a !== 10'd42) val_ok = 1'b0;
        last = c;
        ndone++;
      end
    end
    start_a = 1'b0;
    tests++;
    if (ndone < 3 || !gap_ok || !val_ok) begin
      fails++;
      $display("FAIL back_to_back: got dones=%0d gap_ok=%b val_ok=%b, want >=3 1 1",
               ndone, gap_ok, val_ok);
    end
    for (int c = 0; c < 20 && busy_a; c++) begin
      @(posedge clk);
      #1;
    end
    tests++;
    if (busy_a !== 1'b0) begin
      fails++;
      $display("FAIL back_to_back_idle: got busy=%b, want 0", busy_a);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    bcd_a   = 12'h987;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done_a) saw_done = 1'b1;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({busy_a, done_a, bin_a, err_a, ovf_a} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b bin=%0d err=%b ovf=%b, want all 0",
               busy_a, done_a, bin_a, err_a, ovf_a);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done_a || busy_a) saw_done = 1'b1;
    end
    tests++;
    if (saw_done) begin
      fails++;
      $display("FAIL reset_mid_abort: got done/busy after abort, want none");
    end
    check_conv("after_reset_321", 1'b0, 12'h321);
  endtask

  initial begin
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    bcd_a   = '0;
    bcd_b   = '0;
    test_reset();
    test_directed();
    test_invalid();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
Sequential packed-BCD to binary converter using reverse double dabble: one shift-and-correct step per clock. It is the inverse of our combinational binary-to-BCD block and takes operator/display-domain decimal values back into arithmetic datapaths. It uses a start/busy/done handshake and flags invalid BCD digits and out-of-range results.

Parameters:
DIGITS_IN, 3, number of 4-bit BCD digits on input; digit 0 in bits [3:0]; must be >= 1
BITS_OUT, 10, width of binary result and number of shift iterations; must be >= 1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request conversion; sampled only in IDLE
bcd  input  4*DIGITS_IN  packed BCD operand; sampled on the accepting edge only
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse: result/flags just updated
binary  output  BITS_OUT  converted value; holds until next completion
error  output  1  last operation saw a digit > 9; holds until next completion
overflow  output  1  last value exceeded 2^BITS_OUT-1; holds until next completion

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (clk edge with reset=1): state=IDLE; busy, done, binary, error, overflow all 0; shift register and counter cleared. Reset mid-operation aborts the conversion with no done pulse. Reset has priority over all else.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on edge with start=1:
  - Any digit of bcd > 9 -> state=DONE; done=1, error=1, binary=0, overflow=0 (latency 1 edge).
  - All digits valid -> load working register {bcd_reg, bin_reg} = {bcd, BITS_OUT'b0}; counter=0; state=SHIFT.
- SHIFT: each edge:
  - shift {bcd_reg, bin_reg} right 1 (bcd_reg LSB enters bin_reg MSB; 0 enters bcd_reg MSB);
  - then, for each digit of the shifted bcd_reg, if digit >= 8 subtract 3 (all digits in parallel, same edge);
  - counter += 1.
  - On the edge where counter == BITS_OUT-1 (the BITS_OUT-th shift):
    - binary = shifted bin_reg;
    - overflow = (shifted bcd_reg != 0);
    - error = 0; done = 1; state=DONE.
- DONE: one cycle. Next edge: done=0, state=IDLE. A start during DONE is ignored.
- Timing: start accepted at edge N -> done high in the cycle after edge N+BITS_OUT. Back-to-back throughput is BITS_OUT+2 cycles. With start held high, a new conversion is accepted on the first IDLE edge.
- start and bcd are ignored while busy. bcd changes after acceptance have no effect.
- Overflow result: binary = true value mod 2^BITS_OUT.
- binary, error and overflow change only on the edge that raises done, or on reset.

Test Plan:
- DIGITS_IN=3, BITS_OUT=10: bcd=0x255, start 1 cycle -> busy from next cycle; done pulse exactly 11 cycles after the accepting edge; binary=255, error=0, overflow=0.
- bcd=0x999 -> binary=999 (0x3E7). bcd=0x000 -> binary=0. Both take 11 cycles; flags clear.
- bcd=0x1A3 -> done one cycle after acceptance; error=1, binary=0, overflow=0. A following valid 0x042 -> binary=42, error cleared.
- BITS_OUT=8, bcd=0x300 -> overflow=1, binary=44 (300 mod 256). bcd=0x255 -> overflow=0, binary=255.
- start high with bcd=0x123, then bcd=0x777 and start pulsed mid-conversion -> result 123, busy never drops early. Hold start high continuously -> consecutive done pulses spaced 12 cycles (BITS_OUT=10).
- Assert reset at SHIFT count 5 -> no done; all outputs 0 on the next cycle. A new start then converts normally.
